// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares one register-file write port between two sources:
//   - ALU results, buffered in a 2-entry FIFO.
//   - Memory-load results, which are unbuffered and take priority.
//   A starve counter limits memory priority. After STARVE_LIMIT consecutive
//   memory grants with an ALU entry waiting, the FIFO head is granted instead.
//   The write port outputs are registered, one cycle after the grant.
// Ports
//   clk, rst              clock; synchronous active-high reset
//   alu_valid/rd/data     ALU writeback request; alu_ready = FIFO not full
//   mem_valid/rd/data     load writeback request; mem_ready = MEM granted
//   rf_we/waddr/wdata     registered register-file write port
//   alu_pending           ALU FIFO occupancy (0..2)
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [1:0]  alu_pending
);

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [4:0]    fifo_rd_q   [2];
  logic [31:0]   fifo_data_q [2];
  logic          wptr_q, rptr_q;
  logic [1:0]    count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          rf_we_q;
  logic [4:0]    rf_waddr_q;
  logic [31:0]   rf_wdata_q;

  logic          fifo_empty, push, mem_grant, alu_grant, grant;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_data;

  always_comb begin
    fifo_empty = (count_q == 2'd0);
    alu_ready  = (count_q < 2'd2);
    push       = alu_valid && alu_ready;
    mem_grant  = mem_valid && (starve_q < SW'(STARVE_LIMIT));
    alu_grant  = !mem_grant && !fifo_empty;
    grant      = mem_grant || alu_grant;
    mem_ready  = mem_grant;

    sel_rd   = fifo_rd_q[rptr_q];
    sel_data = fifo_data_q[rptr_q];
    if (mem_grant) begin
      sel_rd   = mem_rd;
      sel_data = mem_data;
    end

    count_d = count_q + {1'b0, push} - {1'b0, alu_grant};

    // The counter only measures memory grants that bypass a waiting entry,
    // so it restarts whenever the FIFO drains or the ALU wins.
    starve_d = starve_q;
    if (alu_grant || fifo_empty) begin
      starve_d = '0;
    end else if (mem_grant) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      count_q    <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      count_q  <= count_d;
      starve_q <= starve_d;
      if (push)      wptr_q <= ~wptr_q;
      if (alu_grant) rptr_q <= ~rptr_q;
      // A grant to $zero is consumed without producing a write.
      rf_we_q <= grant && (sel_rd != 5'd0);
      if (grant) begin
        rf_waddr_q <= sel_rd;
        rf_wdata_q <= sel_data;
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_rd_q[wptr_q]   <= alu_rd;
      fifo_data_q[wptr_q] <= alu_data;
    end
  end

  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign alu_pending = count_q;

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4: the maximum consecutive memory grants while an ALU entry waits.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port alu_valid  input  1  ALU writeback request present.
REQ-005 The block SHALL have port alu_rd  input  5  ALU destination register.
REQ-006 The block SHALL have port alu_data  input  32  ALU result.
REQ-007 The block SHALL have port alu_ready  output  1  ALU request accepted this cycle when alu_valid is also high.
REQ-008 The block SHALL have port mem_valid  input  1  memory-load writeback request present.
REQ-009 The block SHALL have port mem_rd  input  5  load destination register.
REQ-010 The block SHALL have port mem_data  input  32  load data.
REQ-011 The block SHALL have port mem_ready  output  1  memory request accepted this cycle when mem_valid is also high.
REQ-012 The block SHALL have port rf_we  output  1  register-file write enable, registered.
REQ-013 The block SHALL have port rf_waddr  output  5  register-file write address, registered.
REQ-014 The block SHALL have port rf_wdata  output  32  register-file write data, registered.
REQ-015 The block SHALL have port alu_pending  output  2  ALU buffer occupancy, 0 to 2.

Function
REQ-016 The block SHALL share one register-file write port between ALU results, buffered in a 2-entry FIFO, and memory loads, which are unbuffered.
REQ-017 The FIFO SHALL push on alu_valid && alu_ready; alu_ready SHALL be high exactly when alu_pending < 2, using the registered count; a pop in the same cycle SHALL NOT permit a push when the FIFO is full.
REQ-018 Each cycle the arbiter SHALL grant at most one source: MEM if mem_valid and the starve counter is below STARVE_LIMIT; otherwise ALU if the FIFO is non-empty; otherwise none.
REQ-019 mem_ready SHALL be high exactly when MEM is granted; when the starve counter has reached STARVE_LIMIT and the FIFO is non-empty, mem_ready SHALL be low and the FIFO head SHALL be granted.
REQ-020 The starve counter SHALL increment on each MEM grant while the FIFO is non-empty, saturating at STARVE_LIMIT.
REQ-021 The starve counter SHALL clear on any ALU grant and whenever the FIFO is empty.
REQ-022 An ALU grant SHALL pop the FIFO head in that cycle; a push and a pop SHALL be allowed in the same cycle when the FIFO is not full, and alu_pending SHALL then be unchanged.
REQ-023 A grant in cycle N SHALL produce rf_we=1, rf_waddr=rd and rf_wdata=data in cycle N+1; with no grant, rf_we SHALL be 0 in cycle N+1 and rf_waddr/rf_wdata SHALL hold their previous values.
REQ-024 A granted request with rd=0 SHALL be consumed but SHALL produce rf_we=0, so that $zero is never written.
REQ-025 Latency: MEM SHALL be 1 cycle from acceptance to rf_we; ALU SHALL be at least 2 cycles, because an entry pushed at edge E is grantable no earlier than the cycle after E.
REQ-026 The FIFO SHALL preserve ALU ordering; read and write pointers SHALL be 1 bit and wrap modulo 2.
REQ-027 When both sources are idle and the FIFO is empty, all state SHALL hold and rf_we SHALL be 0.

Reset
REQ-028 When rst is high at a clock edge, the block SHALL set the FIFO empty (alu_pending=0, pointers 0), the starve counter to 0, rf_we=0, rf_waddr=0 and rf_wdata=0.
REQ-029 While rst is high, alu_ready SHALL be 1, because it derives from the cleared count.
REQ-030 Reset mid-operation SHALL discard buffered ALU entries and any grant in that cycle, with no rf_we in the following cycle.
REQ-031 Inputs sampled in a cycle with rst high SHALL be ignored.

Verification
REQ-032 Bench SHALL drive a MEM-only request mem_rd=5, mem_data=0xDEADBEEF and require mem_ready=1 and, next cycle, rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-033 Bench SHALL drive an ALU-only request alu_rd=3, data 0x11 at cycle 0 and require alu_pending=1 at cycle 1 and rf_we=1, rf_waddr=3, rf_wdata=0x11 at cycle 2.
REQ-034 Bench SHALL push three ALU requests back-to-back while mem_valid is held high and require alu_ready=0 on the third, alu_pending=2, four MEM grants, then mem_ready=0 and an ALU write of the first entry.
REQ-035 Bench SHALL drive mem_valid with mem_rd=0 and require mem_ready=1 and rf_we=0 the next cycle.
REQ-036 Bench SHALL assert rst for one cycle with alu_pending=2 and mem_valid high and require alu_pending=0, rf_we=0 next cycle and no write of the discarded entries afterwards.
REQ-037 Bench SHALL drive a simultaneous push and pop with alu_pending=1 and require alu_pending to stay 1 and FIFO order to be preserved (entries A then B written in that order).
